// File: rtl/bb_core_pkg.sv
// bb_core_pkg: register indices and PC-operation priority shared by the bb_core datapath
package bb_core_pkg;

    localparam int IDX_IR  = 0;
    localparam int IDX_PC  = 1;
    localparam int IDX_AR  = 2;
    localparam int IDX_CR  = 3;
    localparam int IDX_DR0 = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_WR,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Highest-priority PC request wins; everything below it in the same cycle is discarded
    function automatic pc_op_e pc_op_sel(input logic ret, call, branch, wr, inc);
        return ret ? PC_RET : call ? PC_CALL : branch ? PC_BRANCH : wr ? PC_WR : inc ? PC_INC : PC_HOLD;
    endfunction

endpackage

// File: rtl/bb_register_bank_if.sv
// bb_register_bank_if: control, data and register-view bus between core control and the register bank
interface bb_register_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DR     = 4,
    parameter int SELW       = $clog2(NUM_DR + 4)
);
    logic [DATA_WIDTH-1:0]        i_skin_data;
    logic [DATA_WIDTH-1:0]        i_core_data;
    logic                         i_src_skin;
    logic                         i_wr_en;
    logic [SELW-1:0]              i_wr_sel;
    logic [SELW-1:0]              i_rd_sel;
    logic                         i_rd_inc;
    logic                         i_pc_inc;
    logic                         i_branch;
    logic                         i_call;
    logic                         i_ret;
    logic [DATA_WIDTH-1:0]        i_branch_addr;
    logic [DATA_WIDTH-1:0]        o_reg_value;
    logic [DATA_WIDTH-1:0]        o_instruction;
    logic [DATA_WIDTH-1:0]        o_program_count;
    logic [DATA_WIDTH-1:0]        o_address_reg;
    logic [DATA_WIDTH-1:0]        o_config_reg;
    logic [NUM_DR*DATA_WIDTH-1:0] o_dr_flat;
    logic                         o_stack_full;
    logic                         o_stack_empty;
    logic                         o_stack_err;

    modport master (
        output i_skin_data, i_core_data, i_src_skin, i_wr_en, i_wr_sel, i_rd_sel, i_rd_inc,
               i_pc_inc, i_branch, i_call, i_ret, i_branch_addr,
        input  o_reg_value, o_instruction, o_program_count, o_address_reg, o_config_reg,
               o_dr_flat, o_stack_full, o_stack_empty, o_stack_err
    );

    modport slave (
        input  i_skin_data, i_core_data, i_src_skin, i_wr_en, i_wr_sel, i_rd_sel, i_rd_inc,
               i_pc_inc, i_branch, i_call, i_ret, i_branch_addr,
        output o_reg_value, o_instruction, o_program_count, o_address_reg, o_config_reg,
               o_dr_flat, o_stack_full, o_stack_empty, o_stack_err
    );

endinterface

// File: rtl/bb_ret_stack.sv
// bb_ret_stack: return-address LIFO with sticky overflow/underflow error
module bb_ret_stack #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] top,
    output logic                  full,
    output logic                  empty,
    output logic                  err
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;

    logic [SPW-1:0]        sp;
    logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];

    assign full  = sp == SPW'(STACK_DEPTH);
    assign empty = sp == '0;
    assign top   = empty ? '0 : mem[AW'(sp - SPW'(1))];

    // Entries carry no reset; only the pointer defines what is valid
    always_ff @(posedge clk) begin
        if (push && !full) mem[AW'(sp)] <= push_data;
    end

    // Pointer moves only on legal push/pop; illegal attempts latch the error until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp  <= '0;
            err <= 1'b0;
        end else begin
            if (push && !full) sp <= sp + SPW'(1);
            else if (pop && !empty) sp <= sp - SPW'(1);
            err <= err | (push && full) | (pop && empty);
        end
    end

endmodule

// File: rtl/bb_register_bank.sv
// bb_register_bank: IR/PC/AR/CR plus data registers with indexed access, post-increment and call/return stack
module bb_register_bank
    import bb_core_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  NUM_DR      = 4,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] PC_RESET  = '0
) (
    input logic          clk,
    input logic          rst_n,
    bb_register_bank_if.slave bus
);
    localparam int SELW = $clog2(NUM_DR + 4);

    logic [DATA_WIDTH-1:0] ir, pc, ar, cr, wdata, pc_next, ret_addr, rd_val;
    logic [DATA_WIDTH-1:0] dr [NUM_DR];
    logic                  stk_full, stk_empty;
    pc_op_e                op;

    assign wdata = bus.i_src_skin ? bus.i_skin_data : bus.i_core_data;
    assign op    = pc_op_sel(bus.i_ret, bus.i_call, bus.i_branch,
                             bus.i_wr_en && bus.i_wr_sel == SELW'(IDX_PC), bus.i_pc_inc);

    // A blocked ret/call holds PC; the stack itself records the error
    assign pc_next = op == PC_RET    ? (stk_empty ? pc : ret_addr) :
                     op == PC_CALL   ? (stk_full ? pc : bus.i_branch_addr) :
                     op == PC_BRANCH ? bus.i_branch_addr :
                     op == PC_WR     ? wdata :
                     op == PC_INC    ? pc + DATA_WIDTH'(1) : pc;

    bb_ret_stack #(.DATA_WIDTH(DATA_WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (op == PC_CALL),
        .pop       (op == PC_RET),
        .push_data (pc + DATA_WIDTH'(1)),
        .top       (ret_addr),
        .full      (stk_full),
        .empty     (stk_empty),
        .err       (bus.o_stack_err)
    );

    // Control registers: direct writes, PC follows the priority-resolved next value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
            pc <= PC_RESET;
            ar <= '0;
            cr <= '0;
        end else begin
            pc <= pc_next;
            if (bus.i_wr_en && bus.i_wr_sel == SELW'(IDX_IR)) ir <= wdata;
            if (bus.i_wr_en && bus.i_wr_sel == SELW'(IDX_AR)) ar <= wdata;
            if (bus.i_wr_en && bus.i_wr_sel == SELW'(IDX_CR)) cr <= wdata;
        end
    end

    // Data registers: a write to the same DR overrides its post-increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DR; k++) dr[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_DR; k++) begin
                if (bus.i_wr_en && bus.i_wr_sel == SELW'(IDX_DR0 + k)) dr[k] <= wdata;
                else if (bus.i_rd_inc && bus.i_rd_sel == SELW'(IDX_DR0 + k)) dr[k] <= dr[k] + DATA_WIDTH'(1);
            end
        end
    end

    // Read mux shows the registered value only; unused indices read as zero
    always_comb begin
        rd_val = bus.i_rd_sel == SELW'(IDX_IR) ? ir :
                 bus.i_rd_sel == SELW'(IDX_PC) ? pc :
                 bus.i_rd_sel == SELW'(IDX_AR) ? ar :
                 bus.i_rd_sel == SELW'(IDX_CR) ? cr : '0;
        for (int k = 0; k < NUM_DR; k++)
            if (bus.i_rd_sel == SELW'(IDX_DR0 + k)) rd_val = dr[k];
    end

    assign bus.o_reg_value     = rd_val;
    assign bus.o_instruction   = ir;
    assign bus.o_program_count = pc;
    assign bus.o_address_reg   = ar;
    assign bus.o_config_reg    = cr;
    assign bus.o_stack_full    = stk_full;
    assign bus.o_stack_empty   = stk_empty;

    for (genvar k = 0; k < NUM_DR; k++) begin : g_dr
        assign bus.o_dr_flat[k*DATA_WIDTH +: DATA_WIDTH] = dr[k];
    end

endmodule
